reset_seq_ctrl: RTL and testbench

Power-up and on-demand reset sequencer for banks of preset/clear flip-flops with clock enables. It waits for a lock indication and holds reset for a programmable stretch. It then releases per-domain active-low resets and clock enables one domain at a time, in a fixed order. It sits between the global reset net and the register banks: each `SRN[i]` drives a bank's preset/clear, and each `SP[i]` drives that bank's clock enable.

---
 rtl/reset_seq_pkg.sv | 18 +
 rtl/reset_seq_ctrl_if.sv | 31 +++
 rtl/lock_sync.sv | 24 ++
 rtl/reset_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_reset_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding and DRAIN length.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    STRETCH,
    RELEASE,
    RUN,
    DRAIN
  } state_e;

  localparam int unsigned DRAIN_CYCLES = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_seq_ctrl_if.sv
// Lock/request inputs and per-domain reset/enable outputs of the reset sequencer.
interface reset_seq_ctrl_if #(
  parameter int unsigned NUM_DOMAINS = 4
);

  logic                   LOCK;
  logic                   REQ;
  logic [NUM_DOMAINS-1:0] SRN;
  logic [NUM_DOMAINS-1:0] SP;
  logic                   BUSY;
  logic                   DONE;

  modport master (
    input  LOCK,
    input  REQ,
    output SRN,
    output SP,
    output BUSY,
    output DONE
  );

  modport slave (
    output LOCK,
    output REQ,
    input  SRN,
    input  SP,
    input  BUSY,
    input  DONE
  );

endinterface

// File: rtl/lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the CK domain.
module lock_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: waits for lock, stretches reset, then releases each domain's reset and
// clock enable in ascending order; drains back to HOLD on request or lock loss.
module reset_seq_ctrl #(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned STRETCH     = 16,
  parameter int unsigned STAGE_GAP   = 4
) (
  input  logic              CK,
  input  logic              GSRN,
  reset_seq_ctrl_if.master  bus
);

  import reset_seq_pkg::*;

  localparam int unsigned CntW = $clog2(max_u(STRETCH, STAGE_GAP)) + 1;
  localparam int unsigned IdxW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CntW-1:0]        StretchLast = CntW'(STRETCH - 1);
  localparam logic [CntW-1:0]        GapLast     = CntW'(STAGE_GAP - 1);
  localparam logic [CntW-1:0]        DrainLast   = CntW'(DRAIN_CYCLES - 1);
  localparam logic [IdxW-1:0]        IdxLast     = IdxW'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] Dom0        = NUM_DOMAINS'(1);

  logic                   w_lock_s;
  state_e                 r_state;
  logic [CntW-1:0]        r_cnt;
  logic [IdxW-1:0]        r_idx;
  logic [NUM_DOMAINS-1:0] r_srn;
  logic [NUM_DOMAINS-1:0] r_sp;
  logic                   r_busy;
  logic                   r_done;

  lock_sync u_lock_sync (
    .i_clk   (CK),
    .i_rst_n (GSRN),
    .i_async (bus.LOCK),
    .o_sync  (w_lock_s)
  );

  always_ff @(posedge CK or negedge GSRN) begin
    if (!GSRN) begin
      r_state <= HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_srn   <= '0;
      r_sp    <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        HOLD: begin
          r_srn  <= '0;
          r_sp   <= '0;
          r_busy <= 1'b1;
          r_done <= 1'b0;
          if (w_lock_s) begin
            r_state <= reset_seq_pkg::STRETCH;
            r_cnt   <= '0;
          end
        end
        reset_seq_pkg::STRETCH: begin
          if (!w_lock_s) begin
            r_state <= HOLD;
            r_srn   <= '0;
            r_sp    <= '0;
          end else if (r_cnt == StretchLast) begin
            r_state <= RELEASE;
            r_srn   <= Dom0;
            r_cnt   <= '0;
            r_idx   <= '0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        RELEASE: begin
          if (!w_lock_s) begin
            r_state <= HOLD;
            r_srn   <= '0;
            r_sp    <= '0;
          end else if (r_cnt == GapLast) begin
            r_cnt <= '0;
            r_sp  <= r_sp | (Dom0 << r_idx);
            if (r_idx == IdxLast) begin
              r_state <= RUN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              // Next domain's reset lifts on the same edge this domain's clock enable does.
              r_srn <= r_srn | (Dom0 << (r_idx + IdxW'(1)));
              r_idx <= r_idx + IdxW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        RUN: begin
          if (bus.REQ || !w_lock_s) begin
            r_state <= DRAIN;
            r_sp    <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_cnt   <= '0;
          end
        end
        DRAIN: begin
          // Clock enables are already off; give the banks time to settle before reset.
          if (r_cnt == DrainLast) begin
            r_state <= HOLD;
            r_srn   <= '0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: begin
          r_state <= HOLD;
          r_srn   <= '0;
          r_sp    <= '0;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SRN  = r_srn;
  assign bus.SP   = r_sp;
  assign bus.BUSY = r_busy;
  assign bus.DONE = r_done;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Scoreboard bench for reset_seq_ctrl: drivers queue expected output changes with their edge
// numbers, monitors pop and compare whenever a DUT output actually changes.
module tb_reset_seq_ctrl;

  typedef struct {
    int unsigned at;
    logic [3:0]  srn;
    logic [3:0]  sp;
    logic        busy;
    logic        done;
  } exp_t;

  logic        ck = 1'b0;
  logic        gsrn;
  logic        gsrn_e;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  exp_t        sb_e[$];
  logic [9:0]  last_m = 10'b0000_0000_10;
  logic [9:0]  last_e = 10'b0000_0000_10;
  int unsigned b1, b3, b4, b5, e0;

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  reset_seq_ctrl_if #(.NUM_DOMAINS(4)) bus ();
  reset_seq_ctrl_if #(.NUM_DOMAINS(1)) bus_e ();

  reset_seq_ctrl #(.NUM_DOMAINS(4), .STRETCH(16), .STAGE_GAP(4)) dut (
    .CK   (ck),
    .GSRN (gsrn),
    .bus  (bus)
  );

  reset_seq_ctrl #(.NUM_DOMAINS(1), .STRETCH(1), .STAGE_GAP(1)) dut_e (
    .CK   (ck),
    .GSRN (gsrn_e),
    .bus  (bus_e)
  );

  task automatic check_entry(input string tag, input exp_t e, input exp_t a);
    checks += 2;
    if (a.at != e.at) begin
      errors++;
      $display("FAIL %s timing: change seen at edge %0d, expected at edge %0d", tag, a.at, e.at);
    end
    if ({a.srn, a.sp, a.busy, a.done} !== {e.srn, e.sp, e.busy, e.done}) begin
      errors++;
      $display("FAIL %s value @%0d: SRN=%b SP=%b BUSY=%b DONE=%b, expected SRN=%b SP=%b BUSY=%b DONE=%b",
               tag, a.at, a.srn, a.sp, a.busy, a.done, e.srn, e.sp, e.busy, e.done);
    end
  endtask

  // Main-instance monitor.
  always begin
    exp_t a;
    exp_t e;
    @(bus.SRN or bus.SP or bus.BUSY or bus.DONE);
    #1;
    if ({bus.SRN, bus.SP, bus.BUSY, bus.DONE} !== last_m) begin
      last_m = {bus.SRN, bus.SP, bus.BUSY, bus.DONE};
      a = '{cyc, bus.SRN, bus.SP, bus.BUSY, bus.DONE};
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL main unexpected change @%0d: SRN=%b SP=%b BUSY=%b DONE=%b, expected none",
                 cyc, bus.SRN, bus.SP, bus.BUSY, bus.DONE);
      end else begin
        e = sb.pop_front();
        check_entry("main", e, a);
      end
    end
  end

  // Edge-parameter instance monitor (fields zero-extended to 4 bits).
  always begin
    exp_t a;
    exp_t e;
    @(bus_e.SRN or bus_e.SP or bus_e.BUSY or bus_e.DONE);
    #1;
    if ({3'b000, bus_e.SRN, 3'b000, bus_e.SP, bus_e.BUSY, bus_e.DONE} !== last_e) begin
      last_e = {3'b000, bus_e.SRN, 3'b000, bus_e.SP, bus_e.BUSY, bus_e.DONE};
      a = '{cyc, {3'b000, bus_e.SRN}, {3'b000, bus_e.SP}, bus_e.BUSY, bus_e.DONE};
      if (sb_e.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL edge unexpected change @%0d: SRN=%b SP=%b BUSY=%b DONE=%b, expected none",
                 cyc, bus_e.SRN, bus_e.SP, bus_e.BUSY, bus_e.DONE);
      end else begin
        e = sb_e.pop_front();
        check_entry("edge", e, a);
      end
    end
  end

  // Ordering invariant: a clock enable is never on while its bank is still in reset.
  always @(negedge ck) begin
    checks++;
    if ((bus.SP & ~bus.SRN) != 4'b0000 || (bus_e.SP & ~bus_e.SRN) != 1'b0) begin
      errors++;
      $display("FAIL ordering @%0d: SRN=%b SP=%b / SRN=%b SP=%b, expected SP implies SRN",
               cyc, bus.SRN, bus.SP, bus_e.SRN, bus_e.SP);
    end
  end

  task automatic push(input int unsigned at, input logic [3:0] srn, input logic [3:0] sp,
                      input logic busy, input logic done);
    sb.push_back('{at, srn, sp, busy, done});
  endtask

  task automatic push_e(input int unsigned at, input logic srn, input logic sp,
                        input logic busy, input logic done);
    sb_e.push_back('{at, {3'b000, srn}, {3'b000, sp}, busy, done});
  endtask

  // Full release sequence for defaults, relative to the edge where LOCK is first sampled.
  task automatic push_seq(input int unsigned base);
    push(base + 18, 4'b0001, 4'b0000, 1'b1, 1'b0);
    push(base + 22, 4'b0011, 4'b0001, 1'b1, 1'b0);
    push(base + 26, 4'b0111, 4'b0011, 1'b1, 1'b0);
    push(base + 30, 4'b1111, 4'b0111, 1'b1, 1'b0);
    push(base + 34, 4'b1111, 4'b1111, 1'b0, 1'b1);
  endtask

  // Returns at the falling edge just before absolute edge 'abs'.
  task automatic to_edge(input int unsigned abs);
    @(negedge ck);
    while (cyc + 1 < abs) @(negedge ck);
  endtask

  task automatic wait_empty(input string tag, input int limit);
    for (int i = 0; i < limit && (sb.size() != 0 || sb_e.size() != 0); i++) @(negedge ck);
    checks++;
    if (sb.size() != 0 || sb_e.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: %0d/%0d expected changes pending, expected 0",
               tag, sb.size(), sb_e.size());
      sb.delete();
      sb_e.delete();
    end
  endtask

  task automatic check_now(input string tag, input logic [3:0] srn, input logic [3:0] sp,
                           input logic busy, input logic done);
    checks++;
    if ({bus.SRN, bus.SP, bus.BUSY, bus.DONE} !== {srn, sp, busy, done}) begin
      errors++;
      $display("FAIL %s: SRN=%b SP=%b BUSY=%b DONE=%b, expected SRN=%b SP=%b BUSY=%b DONE=%b",
               tag, bus.SRN, bus.SP, bus.BUSY, bus.DONE, srn, sp, busy, done);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    gsrn      = 1'b1;
    gsrn_e    = 1'b1;
    bus.LOCK  = 1'b0;
    bus.REQ   = 1'b0;
    bus_e.LOCK = 1'b0;
    bus_e.REQ  = 1'b0;
    #1;
    gsrn   = 1'b0;
    gsrn_e = 1'b0;

    // Reset state, with clocks running.
    repeat (3) @(negedge ck);
    check_now("reset_state", 4'b0000, 4'b0000, 1'b1, 1'b0);
    checks++;
    if ({bus_e.SRN, bus_e.SP, bus_e.BUSY, bus_e.DONE} !== 4'b0010) begin
      errors++;
      $display("FAIL edge_reset_state: %b, expected 0010",
               {bus_e.SRN, bus_e.SP, bus_e.BUSY, bus_e.DONE});
    end

    // Power-up with LOCK high from edge 0.
    @(negedge ck);
    gsrn     = 1'b1;
    bus.LOCK = 1'b1;
    b1 = cyc + 1;
    push_seq(b1);
    wait_empty("powerup", 60);

    // Soft reset: REQ pulsed at edge 50, full re-release ending at edge 85.
    push(b1 + 50, 4'b1111, 4'b0000, 1'b1, 1'b0);
    push(b1 + 52, 4'b0000, 4'b0000, 1'b1, 1'b0);
    push_seq(b1 + 51);
    to_edge(b1 + 50);
    bus.REQ = 1'b1;
    @(negedge ck);
    bus.REQ = 1'b0;
    wait_empty("soft_reset", 80);
    checks++;
    if (cyc < b1 + 85) begin
      errors++;
      $display("FAIL soft_reset_done: RUN at edge %0d, expected edge %0d", cyc, b1 + 85);
    end

    // Async reset while in RUN: outputs drop between clock edges.
    @(negedge ck);
    push(cyc, 4'b0000, 4'b0000, 1'b1, 1'b0);
    #1 gsrn = 1'b0;
    #1 check_now("async_run", 4'b0000, 4'b0000, 1'b1, 1'b0);
    repeat (2) @(negedge ck);
    gsrn = 1'b1;
    b3 = cyc + 1;

    // Lock loss in RELEASE: lock_s low at edge 24, relock sampled at edge 30.
    push(b3 + 18, 4'b0001, 4'b0000, 1'b1, 1'b0);
    push(b3 + 22, 4'b0011, 4'b0001, 1'b1, 1'b0);
    push(b3 + 24, 4'b0000, 4'b0000, 1'b1, 1'b0);
    b4 = b3 + 30;
    push_seq(b4);
    to_edge(b3 + 22);
    bus.LOCK = 1'b0;
    to_edge(b3 + 30);
    bus.LOCK = 1'b1;
    wait_empty("lock_loss", 80);

    // Drain into STRETCH, then async reset mid-STRETCH (outputs already low).
    push(b4 + 40, 4'b1111, 4'b0000, 1'b1, 1'b0);
    push(b4 + 42, 4'b0000, 4'b0000, 1'b1, 1'b0);
    to_edge(b4 + 40);
    bus.REQ = 1'b1;
    @(negedge ck);
    bus.REQ = 1'b0;
    to_edge(b4 + 48);
    #1 gsrn = 1'b0;
    #1 check_now("async_stretch", 4'b0000, 4'b0000, 1'b1, 1'b0);
    repeat (3) @(negedge ck);

    // Restart with REQ held high through STRETCH/RELEASE; DRAIN once RUN is reached.
    gsrn    = 1'b1;
    bus.REQ = 1'b1;
    b5 = cyc + 1;
    push_seq(b5);
    push(b5 + 35, 4'b1111, 4'b0000, 1'b1, 1'b0);
    push(b5 + 37, 4'b0000, 4'b0000, 1'b1, 1'b0);
    push_seq(b5 + 36);
    to_edge(b5 + 37);
    bus.REQ = 1'b0;
    wait_empty("req_held", 80);

    // Minimum parameters (1/1/1): SRN[0] at edge 3, SP[0] and DONE at edge 4.
    @(negedge ck);
    gsrn_e     = 1'b1;
    bus_e.LOCK = 1'b1;
    e0 = cyc + 1;
    push_e(e0 + 3, 1'b1, 1'b0, 1'b1, 1'b0);
    push_e(e0 + 4, 1'b1, 1'b1, 1'b0, 1'b1);
    push_e(e0 + 10, 1'b1, 1'b0, 1'b1, 1'b0);
    push_e(e0 + 12, 1'b0, 1'b0, 1'b1, 1'b0);
    push_e(e0 + 14, 1'b1, 1'b0, 1'b1, 1'b0);
    push_e(e0 + 15, 1'b1, 1'b1, 1'b0, 1'b1);
    to_edge(e0 + 10);
    bus_e.REQ = 1'b1;
    @(negedge ck);
    bus_e.REQ = 1'b0;
    wait_empty("edge_params", 40);

    repeat (2) @(negedge ck);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
